spi_cs_txn_ctrl: RTL and testbench

//  Transaction sequencer between a user byte stream and the SPI byte master (SPI_Master).

---
 rtl/spi_cs_txn_ctrl_pkg.sv | 33 +++
 rtl/spi_cs_txn_ctrl_if.sv | 30 +++
 rtl/spi_cs_txn_ctrl_delay_timer.sv | 31 +++
 rtl/spi_cs_txn_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_cs_txn_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cs_txn_ctrl_pkg.sv
// rtl/spi_cs_txn_ctrl_pkg.sv - shared states, timing defaults and helpers for the CS transaction sequencer
package spi_cs_txn_ctrl_pkg;

  localparam int DEF_MAX_BYTES_PER_CS = 2;
  localparam int DEF_CS_SETUP_CLKS    = 2;
  localparam int DEF_CS_HOLD_CLKS     = 2;
  localparam int DEF_CS_INACTIVE_CLKS = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SETUP    = 3'd1;
  localparam state_t ST_SEND     = 3'd2;
  localparam state_t ST_WAIT_RX  = 3'd3;
  localparam state_t ST_NEXT     = 3'd4;
  localparam state_t ST_HOLD     = 3'd5;
  localparam state_t ST_INACTIVE = 3'd6;

  // Largest of the three CS gaps; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A request of 0 bytes still clocks one byte; requests above the window size are cut to it.
  function automatic int clamp_count(input int cnt, input int max_n);
    if (cnt == 0) return 1;
    if (cnt > max_n) return max_n;
    return cnt;
  endfunction

endpackage

// File: rtl/spi_cs_txn_ctrl_if.sv
// rtl/spi_cs_txn_ctrl_if.sv - user stream and byte-engine signals of the CS transaction sequencer
interface spi_cs_txn_ctrl_if #(
  parameter int CW = 2
);
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [CW-1:0] o_RX_Count;
  logic [7:0]    o_Eng_TX_Byte;
  logic          o_Eng_TX_DV;
  logic          i_Eng_TX_Ready;
  logic          i_Eng_RX_DV;
  logic [7:0]    i_Eng_RX_Byte;
  logic          o_SPI_CS_n;

  // Sequencer side.
  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_Eng_TX_Byte, o_Eng_TX_DV, o_SPI_CS_n
  );

  // User and byte-engine side.
  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_Eng_TX_Ready, i_Eng_RX_DV, i_Eng_RX_Byte,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_Eng_TX_Byte, o_Eng_TX_DV, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_cs_txn_ctrl_delay_timer.sv
// rtl/spi_cs_txn_ctrl_delay_timer.sv - loadable down-counter that flags the last cycle of a CS gap
module spi_delay_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load on start, otherwise count down to zero and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A load of N keeps done low for N-1 cycles and high on the Nth.
  assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/spi_cs_txn_ctrl.sv
// rtl/spi_cs_txn_ctrl.sv - groups user bytes under one chip-select window around an SPI byte engine
module spi_cs_txn_ctrl
  import spi_cs_txn_ctrl_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = DEF_MAX_BYTES_PER_CS,
  parameter int CS_SETUP_CLKS    = DEF_CS_SETUP_CLKS,
  parameter int CS_HOLD_CLKS     = DEF_CS_HOLD_CLKS,
  parameter int CS_INACTIVE_CLKS = DEF_CS_INACTIVE_CLKS
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  spi_cs_txn_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int TW = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_INACTIVE_CLKS) + 1);

  state_t        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_dv_q, rx_dv_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic [7:0]    eng_byte_q, eng_byte_d;
  logic          eng_dv_q, eng_dv_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          tmr_start, tmr_done;
  logic [TW-1:0] tmr_load;
  logic          accept;

  spi_delay_timer #(.W(TW)) u_timer (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .start_i (tmr_start),
    .load_i  (tmr_load),
    .done_o  (tmr_done)
  );

  assign accept = bus.i_TX_DV & tx_ready_q;

  // Next-state and output decode; engine DV is issued straight out of SETUP when the gap ends.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    rx_dv_d    = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_count_d = rx_count_q;
    eng_byte_d = eng_byte_q;
    eng_dv_d   = 1'b0;
    rem_d      = rem_q;
    idx_d      = idx_q;
    tmr_start  = 1'b0;
    tmr_load   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          eng_byte_d = bus.i_TX_Byte;
          rem_d      = CW'(clamp_count(int'(bus.i_TX_Count), MAX_BYTES_PER_CS));
          idx_d      = '0;
          rx_count_d = '0;
          cs_n_d     = 1'b0;
          tmr_start  = 1'b1;
          tmr_load   = TW'(CS_SETUP_CLKS);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          if (bus.i_Eng_TX_Ready) begin
            eng_dv_d = 1'b1;
            state_d  = ST_WAIT_RX;
          end else begin
            state_d  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (bus.i_Eng_TX_Ready) begin
          eng_dv_d = 1'b1;
          state_d  = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (bus.i_Eng_RX_DV) begin
          rx_dv_d    = 1'b1;
          rx_byte_d  = bus.i_Eng_RX_Byte;
          rx_count_d = idx_q;
          idx_d      = idx_q + CW'(1);
          rem_d      = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            tmr_start = 1'b1;
            tmr_load  = TW'(CS_HOLD_CLKS);
            state_d   = ST_HOLD;
          end else begin
            state_d   = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (accept) begin
          eng_byte_d = bus.i_TX_Byte;
          state_d    = ST_SEND;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          cs_n_d    = 1'b1;
          tmr_start = 1'b1;
          tmr_load  = TW'(CS_INACTIVE_CLKS);
          state_d   = ST_INACTIVE;
        end
      end
      ST_INACTIVE: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    tx_ready_d = ((state_d == ST_IDLE) || (state_d == ST_NEXT)) && bus.i_Eng_TX_Ready;
  end

  // State and registered outputs; reset drops any in-flight byte and raises CS.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      cs_n_q     <= 1'b1;
      tx_ready_q <= 1'b0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      rx_count_q <= '0;
      eng_byte_q <= '0;
      eng_dv_q   <= 1'b0;
      rem_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
      rx_dv_q    <= rx_dv_d;
      rx_byte_q  <= rx_byte_d;
      rx_count_q <= rx_count_d;
      eng_byte_q <= eng_byte_d;
      eng_dv_q   <= eng_dv_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.o_SPI_CS_n    = cs_n_q;
  assign bus.o_TX_Ready    = tx_ready_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_RX_Count    = rx_count_q;
  assign bus.o_Eng_TX_Byte = eng_byte_q;
  assign bus.o_Eng_TX_DV   = eng_dv_q;
endmodule

// File: tb/tb_spi_cs_txn_ctrl.sv
// tb/tb_spi_cs_txn_ctrl.sv - directed vector bench for the CS transaction sequencer
module tb_spi_cs_txn_ctrl;
  localparam int CW      = 2;
  localparam int ENG_LAT = 12;
  localparam int TMO     = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_cs_txn_ctrl_if #(.CW(CW)) bus();
  spi_cs_txn_ctrl dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0, eng_dv_total = 0, fall_total = 0, rise_total = 0;
  int fall_cyc = 0, rise_cyc = 0, first_dv_cyc = -1, erx_cyc = -100;
  int min_gap = 1000, viol = 0, rx_lat_bad = 0, win_dv = 0;
  int eng_busy = 0, eng_cnt = 0;
  logic [7:0] eng_data = 8'h00;
  logic cs_prev = 1'b1;
  logic [7:0]    rx_q[$];
  logic [CW-1:0] rxc_q[$];
  int            win_q[$];

  typedef struct {
    int         cnt;
    logic [7:0] b0;
    logic [7:0] b1;
    int         gap;
    int         extra;
    int         n;
    logic [7:0] r0;
    logic [7:0] r1;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s: got %0d, expected at least %0d", nm, act, lim);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Observe outputs at the falling edge, then step the loopback engine (MISO = MOSI ^ 0x99).
  initial begin : mon
    bus.i_Eng_TX_Ready = 1'b1;
    bus.i_Eng_RX_DV    = 1'b0;
    bus.i_Eng_RX_Byte  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (cs_prev && !bus.o_SPI_CS_n) begin
        fall_total++;
        fall_cyc = cyc;
        if (rise_total > 0 && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
        first_dv_cyc = -1;
        win_dv = 0;
      end
      if (!cs_prev && bus.o_SPI_CS_n) begin
        rise_total++;
        rise_cyc = cyc;
        win_q.push_back(win_dv);
      end
      if (bus.o_Eng_TX_DV) begin
        eng_dv_total++;
        win_dv++;
        if (first_dv_cyc < 0) first_dv_cyc = cyc;
        if (!bus.i_Eng_TX_Ready || eng_busy != 0 || bus.o_SPI_CS_n) viol++;
      end
      if (bus.o_RX_DV) begin
        rx_q.push_back(bus.o_RX_Byte);
        rxc_q.push_back(bus.o_RX_Count);
        if (cyc - erx_cyc != 1) rx_lat_bad++;
      end
      cs_prev = bus.o_SPI_CS_n;
      bus.i_Eng_RX_DV = 1'b0;
      if (rst) begin
        eng_busy = 0;
        bus.i_Eng_TX_Ready = 1'b1;
      end else if (eng_busy != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.i_Eng_RX_DV    = 1'b1;
          bus.i_Eng_RX_Byte  = eng_data ^ 8'h99;
          erx_cyc            = cyc;
          eng_busy           = 0;
          bus.i_Eng_TX_Ready = 1'b1;
        end
      end else if (bus.o_Eng_TX_DV) begin
        eng_busy           = 1;
        eng_cnt            = ENG_LAT;
        eng_data           = bus.o_Eng_TX_Byte;
        bus.i_Eng_TX_Ready = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int cnt);
    int t;
    t = 0;
    bus.i_TX_Byte  = b;
    bus.i_TX_Count = CW'(cnt);
    bus.i_TX_DV    = 1'b1;
    while (!bus.o_TX_Ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout("tx_accept");
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
  endtask

  task automatic pulse_dv();
    bus.i_TX_Byte = 8'hEE;
    bus.i_TX_DV   = 1'b1;
    @(negedge clk);
    bus.i_TX_DV   = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout("rx_wait");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(bus.o_SPI_CS_n && bus.o_TX_Ready) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout("idle_wait");
  endtask

  initial begin : main
    int base_dv, base_rx, base_fall, base_rise, base_w, t;
    bus.i_TX_DV    = 1'b0;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_Count = '0;

    // cnt, b0, b1, gap before b1, stray DV pulse, bytes clocked, rx0, rx1
    vt[0] = '{1, 8'hA5, 8'h00, 0,  0, 1, 8'h3C, 8'h00};
    vt[1] = '{2, 8'h11, 8'h22, 10, 0, 2, 8'h88, 8'hBB};
    vt[2] = '{0, 8'h5A, 8'h00, 0,  1, 1, 8'hC3, 8'h00};
    vt[3] = '{3, 8'h0F, 8'hF0, 0,  1, 2, 8'h96, 8'h69};
    vt[4] = '{2, 8'h00, 8'hFF, 0,  0, 2, 8'h99, 8'h66};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(bus.o_SPI_CS_n), 1);
    chk("rst_tx_ready", int'(bus.o_TX_Ready), 0);
    chk("rst_rx_dv", int'(bus.o_RX_DV), 0);
    chk("rst_eng_dv", int'(bus.o_Eng_TX_DV), 0);
    chk("rst_rx_byte", int'(bus.o_RX_Byte), 0);
    chk("rst_rx_count", int'(bus.o_RX_Count), 0);
    chk("rst_eng_byte", int'(bus.o_Eng_TX_Byte), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.o_TX_Ready), 1);

    for (int i = 0; i < 5; i++) begin
      base_dv   = eng_dv_total;
      base_rx   = rx_q.size();
      base_fall = fall_total;
      base_rise = rise_total;
      send_byte(vt[i].b0, vt[i].cnt);
      if (vt[i].extra != 0) pulse_dv();
      if (vt[i].n == 2) begin
        wait_rx(base_rx + 1);
        repeat (vt[i].gap) @(negedge clk);
        send_byte(vt[i].b1, 1);
        if (vt[i].extra != 0) pulse_dv();
      end
      wait_rx(base_rx + vt[i].n);
      wait_idle();
      chk($sformatf("v%0d_bytes", i), eng_dv_total - base_dv, vt[i].n);
      chk($sformatf("v%0d_rx0", i), int'(rx_q[base_rx]), int'(vt[i].r0));
      chk($sformatf("v%0d_idx0", i), int'(rxc_q[base_rx]), 0);
      if (vt[i].n == 2) begin
        chk($sformatf("v%0d_rx1", i), int'(rx_q[base_rx + 1]), int'(vt[i].r1));
        chk($sformatf("v%0d_idx1", i), int'(rxc_q[base_rx + 1]), 1);
      end
      chk($sformatf("v%0d_cs_falls", i), fall_total - base_fall, 1);
      chk($sformatf("v%0d_cs_rises", i), rise_total - base_rise, 1);
      chk($sformatf("v%0d_setup", i), first_dv_cyc - fall_cyc, 2);
      chk($sformatf("v%0d_hold", i), rise_cyc - erx_cyc, 3);
    end

    // Reset while byte 0 of a 2-byte transaction is on the wire.
    base_dv = eng_dv_total;
    base_rx = rx_q.size();
    send_byte(8'h77, 2);
    t = 0;
    while (eng_dv_total == base_dv && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout("midrst_dv");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", int'(bus.o_SPI_CS_n), 1);
    chk("midrst_rx_dv", int'(bus.o_RX_DV), 0);
    chk("midrst_eng_dv", int'(bus.o_Eng_TX_DV), 0);
    repeat (ENG_LAT + 4) @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_rx", rx_q.size() - base_rx, 0);
    base_dv = eng_dv_total;
    send_byte(8'h42, 1);
    wait_rx(base_rx + 1);
    wait_idle();
    chk("post_rst_bytes", eng_dv_total - base_dv, 1);
    chk("post_rst_rx", int'(rx_q[base_rx]), 8'hDB);
    chk("post_rst_idx", int'(rxc_q[base_rx]), 0);

    // i_TX_DV held high: every window carries exactly two bytes.
    base_w    = win_q.size();
    base_rise = rise_total;
    base_rx   = rx_q.size();
    bus.i_TX_Count = CW'(2);
    bus.i_TX_Byte  = 8'h30;
    bus.i_TX_DV    = 1'b1;
    t = 0;
    while (rise_total - base_rise < 2 && t < 4 * TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4 * TMO) timeout("held_dv");
    bus.i_TX_DV = 1'b0;
    wait_idle();
    chk("held_win0", win_q[base_w], 2);
    chk("held_win1", win_q[base_w + 1], 2);
    chk("held_idx0", int'(rxc_q[base_rx]), 0);
    chk("held_idx1", int'(rxc_q[base_rx + 1]), 1);
    chk("held_idx2", int'(rxc_q[base_rx + 2]), 0);
    chk("held_rx3", int'(rx_q[base_rx + 3]), 8'hA9);

    chk_ge("cs_inactive_gap", min_gap, 4);
    chk("handshake_viol", viol, 0);
    chk("rx_latency", rx_lat_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
